c_wait_merge_n_d: RTL and testbench

//  N-way synchronous wait-merge with data persistence, N >= 2, one clock domain.
//  - Collects one drive pulse per enabled input channel; latches each channel's data on arrival.
//  - When all enabled channels have arrived: one o_drive_next pulse downstream with the concatenated data.
//  - On i_free_next: one o_free pulse on every enabled channel; waits for the next round.
//  - Sits at join points of the control/data pipeline; replaces fixed 2-way delay-based merges.

---
 rtl/c_ctrl_pkg.sv | 20 ++
 rtl/c_merge_slot.sv | 36 +++
 rtl/c_wait_merge_n_d.sv | 134 +++++++++++++
 tb/tb_c_wait_merge_n_d.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/c_ctrl_pkg.sv
// Shared control definitions for the wait-merge join: FSM state encoding
// and the completion test used to decide when a round may fire.
package c_ctrl_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {
        ST_COLLECT   = 2'd0,
        ST_FIRE      = 2'd1,
        ST_WAIT_FREE = 2'd2
    } state_t;

    // Channels beyond N_CH must be passed with mask=0 so they count as arrived.
    // An all-zero mask never completes, so a fully disabled join stays idle.
    function automatic logic all_arrived(input logic [MAX_CH-1:0] arrived,
                                         input logic [MAX_CH-1:0] mask);
        return (&(arrived | ~mask)) && (|mask);
    endfunction

endpackage

// File: rtl/c_merge_slot.sv
// One channel of the wait-merge: arrival flag plus the data captured on the
// first accepted drive of the round.
module c_merge_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  accept,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  arrived,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  dup_err
);

    logic                  arrived_reg;
    logic [DATA_WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            arrived_reg <= 1'b0;
            data_reg    <= '0;
        end else if (clear) begin
            arrived_reg <= 1'b0;
        end else if (accept && !arrived_reg) begin
            arrived_reg <= 1'b1;
            data_reg    <= data_in;
        end
    end

    // A second drive in the same round is dropped and flagged upstream.
    assign dup_err = accept & arrived_reg;
    assign arrived = arrived_reg;
    assign data    = data_reg;

endmodule

// File: rtl/c_wait_merge_n_d.sv
// N-way wait-merge: collects one drive per enabled channel, fires a single
// merged drive downstream, then releases every enabled channel on free.
module c_wait_merge_n_d
    import c_ctrl_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            i_drive,
    input  logic [N_CH*DATA_WIDTH-1:0] i_data,
    input  logic [N_CH-1:0]            i_mask,
    output logic [N_CH-1:0]            o_free,
    output logic                       o_drive_next,
    input  logic                       i_free_next,
    output logic [N_CH*DATA_WIDTH-1:0] o_data,
    output logic                       o_err
);

    localparam int DW = DATA_WIDTH;

    state_t state_reg, state_next;

    logic                 in_collect;
    logic [N_CH-1:0]      accept;
    logic [N_CH-1:0]      new_arr;
    logic [N_CH-1:0]      arrived;
    logic [N_CH-1:0]      dup_err;
    logic [N_CH*DW-1:0]   slot_data;
    logic [N_CH*DW-1:0]   merged;
    logic [MAX_CH-1:0]    arr_ext;
    logic [MAX_CH-1:0]    mask_ext;
    logic                 all_done;
    logic                 fire;
    logic                 release_ch;
    logic                 err_event;

    logic [N_CH-1:0]      en_q_reg;
    logic [N_CH-1:0]      free_reg;
    logic                 drive_next_reg;
    logic [N_CH*DW-1:0]   data_out_reg;
    logic                 err_reg;

    assign in_collect = (state_reg == ST_COLLECT);
    assign accept     = i_drive & i_mask & {N_CH{in_collect}};
    assign new_arr    = accept & ~arrived;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_slot
            c_merge_slot #(.DATA_WIDTH(DW)) u_slot (
                .clk     (clk),
                .rst     (rst),
                .accept  (accept[gi]),
                .clear   (release_ch),
                .data_in (i_data[gi*DW +: DW]),
                .arrived (arrived[gi]),
                .data    (slot_data[gi*DW +: DW]),
                .dup_err (dup_err[gi])
            );

            // Bypass the slot register so the last arrival's data rides the fire edge.
            assign merged[gi*DW +: DW] = !i_mask[gi] ? '0 :
                                         new_arr[gi] ? i_data[gi*DW +: DW] :
                                                       slot_data[gi*DW +: DW];
        end
    endgenerate

    always_comb begin
        arr_ext  = '0;
        mask_ext = '0;
        arr_ext[N_CH-1:0]  = arrived | new_arr;
        mask_ext[N_CH-1:0] = i_mask;
    end

    assign all_done = all_arrived(arr_ext, mask_ext);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_COLLECT;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        fire       = 1'b0;
        release_ch = 1'b0;
        case (state_reg)
            ST_COLLECT: begin
                if (all_done) begin
                    state_next = ST_FIRE;
                    fire       = 1'b1;
                end
            end
            ST_FIRE: begin
                state_next = ST_WAIT_FREE;
            end
            ST_WAIT_FREE: begin
                if (i_free_next) begin
                    state_next = ST_COLLECT;
                    release_ch = 1'b1;
                end
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    assign err_event = (|dup_err)
                     | (!in_collect && (|i_drive))
                     | (in_collect && i_free_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q_reg       <= '0;
            free_reg       <= '0;
            drive_next_reg <= 1'b0;
            data_out_reg   <= '0;
            err_reg        <= 1'b0;
        end else begin
            drive_next_reg <= fire;
            free_reg       <= release_ch ? en_q_reg : '0;
            if (fire) begin
                en_q_reg     <= i_mask;
                data_out_reg <= merged;
            end
            if (err_event) err_reg <= 1'b1;
        end
    end

    assign o_free       = free_reg;
    assign o_drive_next = drive_next_reg;
    assign o_data       = data_out_reg;
    assign o_err        = err_reg;

endmodule

// File: tb/tb_c_wait_merge_n_d.sv
// Directed-vector bench for the 4-channel, 8-bit wait-merge join.
module tb_c_wait_merge_n_d;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    i_drive;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    i_mask;
    logic [N-1:0]    o_free;
    logic            o_drive_next;
    logic            i_free_next;
    logic [N*DW-1:0] o_data;
    logic            o_err;

    int n_cmp = 0;
    int n_bad = 0;

    c_wait_merge_n_d #(.N_CH(N), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_drive      (i_drive),
        .i_data       (i_data),
        .i_mask       (i_mask),
        .o_free       (o_free),
        .o_drive_next (o_drive_next),
        .i_free_next  (i_free_next),
        .o_data       (o_data),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle of stimulus, advance past the edge, then idle the pulses.
    task automatic drv(input logic [N-1:0] d, input logic [31:0] data,
                       input logic [N-1:0] m, input logic fn);
        i_drive     = d;
        i_data      = data;
        i_mask      = m;
        i_free_next = fn;
        step();
        i_drive     = '0;
        i_free_next = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        i_drive     = '0;
        i_data      = '0;
        i_mask      = 4'hF;
        i_free_next = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_drive_next", {31'd0, o_drive_next}, 32'd0);
        chk("rst_free", {28'd0, o_free}, 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);

        // 1: staggered arrivals on cycles 1,3,5,7
        drv(4'b0001, 32'h0000_0011, 4'hF, 1'b0);
        drv(4'b0000, 32'h0, 4'hF, 1'b0);
        drv(4'b0010, 32'h0000_2200, 4'hF, 1'b0);
        drv(4'b0000, 32'h0, 4'hF, 1'b0);
        drv(4'b0100, 32'h0033_0000, 4'hF, 1'b0);
        chk("t1_no_early_fire", {31'd0, o_drive_next}, 32'd0);
        drv(4'b0000, 32'h0, 4'hF, 1'b0);
        drv(4'b1000, 32'h4400_0000, 4'hF, 1'b0);
        chk("t1_drive_next", {31'd0, o_drive_next}, 32'd1);
        chk("t1_data", o_data, 32'h4433_2211);
        drv(4'b0000, 32'h0, 4'hF, 1'b0);
        chk("t1_drive_pulse", {31'd0, o_drive_next}, 32'd0);
        chk("t1_data_held", o_data, 32'h4433_2211);
        drv(4'b0000, 32'h0, 4'hF, 1'b0);
        drv(4'b0000, 32'h0, 4'hF, 1'b0);
        drv(4'b0000, 32'h0, 4'hF, 1'b0);
        chk("t1_no_free_yet", {28'd0, o_free}, 32'd0);
        drv(4'b0000, 32'h0, 4'hF, 1'b1);
        chk("t1_free", {28'd0, o_free}, 32'hF);
        drv(4'b0000, 32'h0, 4'hF, 1'b0);
        chk("t1_free_pulse", {28'd0, o_free}, 32'd0);
        chk("t1_err", {31'd0, o_err}, 32'd0);

        // 2: simultaneous drives, then a second round
        do_reset();
        drv(4'b0000, 32'h0, 4'hF, 1'b0);
        drv(4'b1111, 32'hDDCC_BBAA, 4'hF, 1'b0);
        chk("t2_drive_next", {31'd0, o_drive_next}, 32'd1);
        chk("t2_data", o_data, 32'hDDCC_BBAA);
        drv(4'b0000, 32'h0, 4'hF, 1'b0);
        chk("t2_drive_pulse", {31'd0, o_drive_next}, 32'd0);
        drv(4'b0000, 32'h0, 4'hF, 1'b1);
        chk("t2_free", {28'd0, o_free}, 32'hF);
        drv(4'b1111, 32'h0403_0201, 4'hF, 1'b0);
        chk("t2_r2_drive_next", {31'd0, o_drive_next}, 32'd1);
        chk("t2_r2_data", o_data, 32'h0403_0201);
        drv(4'b0000, 32'h0, 4'hF, 1'b0);
        drv(4'b0000, 32'h0, 4'hF, 1'b1);
        chk("t2_r2_free", {28'd0, o_free}, 32'hF);
        chk("t2_err", {31'd0, o_err}, 32'd0);

        // 3: channels 1 and 3 masked off
        do_reset();
        drv(4'b0001, 32'hEEEE_EE11, 4'b0101, 1'b0);
        chk("t3_no_early_fire", {31'd0, o_drive_next}, 32'd0);
        drv(4'b0100, 32'hFF33_FFFF, 4'b0101, 1'b0);
        chk("t3_drive_next", {31'd0, o_drive_next}, 32'd1);
        chk("t3_data", o_data, 32'h0033_0011);
        drv(4'b0000, 32'h0, 4'b0101, 1'b0);
        drv(4'b0000, 32'h0, 4'b0101, 1'b1);
        chk("t3_free", {28'd0, o_free}, 32'h5);

        // 4: duplicate drive on ch1
        do_reset();
        drv(4'b0010, 32'h0000_2200, 4'hF, 1'b0);
        chk("t4_err_before", {31'd0, o_err}, 32'd0);
        drv(4'b0010, 32'h0000_9900, 4'hF, 1'b0);
        chk("t4_err_dup", {31'd0, o_err}, 32'd1);
        drv(4'b0001, 32'h0000_0011, 4'hF, 1'b0);
        drv(4'b1100, 32'h4433_0000, 4'hF, 1'b0);
        chk("t4_drive_next", {31'd0, o_drive_next}, 32'd1);
        chk("t4_data", o_data, 32'h4433_2211);

        // 5: early free during collect
        do_reset();
        drv(4'b0001, 32'h0000_0011, 4'hF, 1'b0);
        drv(4'b0000, 32'h0, 4'hF, 1'b1);
        chk("t5_err", {31'd0, o_err}, 32'd1);
        chk("t5_no_free", {28'd0, o_free}, 32'd0);
        drv(4'b1110, 32'h4433_2200, 4'hF, 1'b0);
        chk("t5_drive_next", {31'd0, o_drive_next}, 32'd1);
        chk("t5_data", o_data, 32'h4433_2211);

        // 6: reset mid-round
        do_reset();
        drv(4'b0111, 32'h0033_2211, 4'hF, 1'b0);
        chk("t6_no_fire", {31'd0, o_drive_next}, 32'd0);
        drv(4'b0001, 32'h0000_0055, 4'hF, 1'b0);
        chk("t6_err_set", {31'd0, o_err}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_drive_next", {31'd0, o_drive_next}, 32'd0);
        chk("t6_rst_err", {31'd0, o_err}, 32'd0);
        chk("t6_rst_data", o_data, 32'd0);
        drv(4'b1000, 32'h4400_0000, 4'hF, 1'b0);
        chk("t6_needs_all", {31'd0, o_drive_next}, 32'd0);
        drv(4'b0111, 32'h0003_0201, 4'hF, 1'b0);
        chk("t6_drive_next", {31'd0, o_drive_next}, 32'd1);
        chk("t6_data", o_data, 32'h4403_0201);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
